// File: rtl/char_write_ctrl.sv
// Character write sequencer for the Apple-1 circulating display memory: waits for the
// cursor slot to come round, issues one write, advances the cursor and requests scrolls.
module char_write_ctrl #(
  parameter int unsigned COLS  = 40,
  parameter int unsigned ROWS  = 24,
  parameter int unsigned POS_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             da,
  input  logic [6:0]       char_in,
  input  logic             shift_en,
  input  logic             frame_sync,
  input  logic             clr,
  input  logic             scroll_done,
  output logic             wr_en,
  output logic [6:0]       wr_data,
  output logic             rda,
  output logic             scroll_req,
  output logic [POS_W-1:0] cursor_pos,
  output logic             busy
);

  localparam int unsigned ColW = $clog2(COLS);
  localparam logic [POS_W-1:0] LastSlot     = POS_W'(COLS * ROWS - 1);
  localparam logic [POS_W-1:0] LastRowStart = POS_W'((ROWS - 1) * COLS);
  localparam logic [POS_W-1:0] RowStride    = POS_W'(COLS);
  localparam logic [ColW-1:0]  LastCol      = ColW'(COLS - 1);

  typedef enum logic [2:0] {
    StIdle, StWaitSlot, StAdvance, StScroll, StAck, StHold
  } state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] slot_q, slot_d;
  logic [POS_W-1:0] cursor_q, cursor_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [6:0]       data_q, data_d;
  logic             newline_q, newline_d;
  logic             scroll_first_q, scroll_first_d;
  logic [6:0]       folded;

  // Lower-case range folds onto upper case by dropping bit 5.
  always_comb begin
    folded = char_in;
    if (char_in[6:5] == 2'b11) folded[5] = 1'b0;
  end

  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    cursor_d       = cursor_q;
    col_d          = col_q;
    data_d         = data_q;
    newline_d      = newline_q;
    scroll_first_d = scroll_first_q;
    wr_en          = 1'b0;
    rda            = 1'b0;
    scroll_req     = 1'b0;

    if (frame_sync) begin
      slot_d = '0;
    end else if (shift_en) begin
      slot_d = (slot_q == LastSlot) ? '0 : slot_q + POS_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (da) begin
          data_d    = folded;
          newline_d = 1'b0;
          if (folded >= 7'h20) begin
            state_d = StWaitSlot;
          end else if (folded == 7'h0D) begin
            newline_d = 1'b1;
            state_d   = StAdvance;
          end else begin
            state_d = StAck;
          end
        end
      end
      StWaitSlot: begin
        if (shift_en && (slot_q == cursor_q)) begin
          wr_en   = 1'b1;
          state_d = StAdvance;
        end
      end
      StAdvance: begin
        if (newline_q || (col_q == LastCol)) begin
          col_d = '0;
          if (cursor_q >= LastRowStart) begin
            cursor_d       = LastRowStart;
            scroll_first_d = 1'b1;
            state_d        = StScroll;
          end else begin
            cursor_d = cursor_q - {{(POS_W - ColW){1'b0}}, col_q} + RowStride;
            state_d  = StAck;
          end
        end else begin
          col_d    = col_q + ColW'(1);
          cursor_d = cursor_q + POS_W'(1);
          state_d  = StAck;
        end
      end
      StScroll: begin
        scroll_req     = scroll_first_q;
        scroll_first_d = 1'b0;
        if (scroll_done) state_d = StAck;
      end
      StAck: begin
        rda     = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (!da) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Clear drops any pending character; the slot counter keeps tracking the memory.
    if (clr) begin
      state_d        = StIdle;
      cursor_d       = '0;
      col_d          = '0;
      scroll_first_d = 1'b0;
      wr_en          = 1'b0;
      rda            = 1'b0;
      scroll_req     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      slot_q         <= '0;
      cursor_q       <= '0;
      col_q          <= '0;
      data_q         <= '0;
      newline_q      <= 1'b0;
      scroll_first_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      cursor_q       <= cursor_d;
      col_q          <= col_d;
      data_q         <= data_d;
      newline_q      <= newline_d;
      scroll_first_q <= scroll_first_d;
    end
  end

  assign wr_data    = data_q;
  assign cursor_pos = cursor_q;
  assign busy       = (state_q != StIdle);

endmodule
